// File: rtl/zuc256_ctr_sequencer.sv
// Message-level sequencer in front of the ZUC-256 CTR stage.
// Latches key/IV/length, issues one init request, then streams plaintext words through the
// CTR stage one at a time, returning each result with a last-word flag. Every wait on the CTR
// stage is guarded by a watchdog, and an abort while a request is outstanding drains the reply.
module zuc256_ctr_sequencer #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [255:0]     key,
    input  logic [127:0]     iv,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             ctr_init,
    output logic             ctr_next,
    output logic [255:0]     ctr_key,
    output logic [127:0]     ctr_iv,
    output logic [31:0]      ctr_word_i,
    input  logic [31:0]      ctr_word_o,
    input  logic             ctr_ready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInitWait,
        StFetch,
        StNextWait,
        StEmit,
        StDrain,
        StErr
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    wdog_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [255:0]       key_q;
    logic [127:0]       iv_q;
    logic [31:0]        word_q;
    logic [31:0]        out_data_q;
    logic               out_last_q;
    logic               ctr_init_q;
    logic               ctr_next_q;
    logic               done_q;

    logic               timeout_hit;
    logic               waiting;
    logic               start_go;
    logic               zero_done;
    logic               fetch_hs;
    logic               word_done;
    logic               last_hs;

    // Decoded strobes; abort always takes priority over any other event in the same cycle.
    always_comb begin
        timeout_hit = (wdog_q == CntW'(TIMEOUT));
        waiting     = (state_q == StInitWait) || (state_q == StNextWait) ||
                      (state_q == StDrain);
        start_go    = (state_q == StIdle) && start && !abort && (msg_len != '0);
        zero_done   = (state_q == StIdle) && start && !abort && (msg_len == '0);
        fetch_hs    = (state_q == StFetch) && in_valid && !abort;
        word_done   = (state_q == StNextWait) && ctr_ready && !abort;
        last_hs     = (state_q == StEmit) && out_ready && !abort && out_last_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_go) begin
                    state_d = StInitWait;
                end
            end
            StInitWait: begin
                // An abort coinciding with the reply needs no drain: nothing is outstanding.
                if (abort) begin
                    state_d = ctr_ready ? StIdle : StDrain;
                end else if (ctr_ready) begin
                    state_d = StFetch;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StFetch: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (in_valid) begin
                    state_d = StNextWait;
                end
            end
            StNextWait: begin
                if (abort) begin
                    state_d = ctr_ready ? StIdle : StDrain;
                end else if (ctr_ready) begin
                    state_d = StEmit;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end
            end
            StEmit: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (out_ready) begin
                    state_d = out_last_q ? StIdle : StFetch;
                end
            end
            StDrain: begin
                if (ctr_ready || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                if (abort) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (state_q != StIdle);
        error     = (state_q == StErr);
        in_ready  = (state_q == StFetch);
        out_valid = (state_q == StEmit);
    end

    // Watchdog: restarts on entry to any CTR wait state, saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else if (state_d != state_q) begin
            wdog_q <= '0;
        end else if (waiting && !timeout_hit) begin
            wdog_q <= wdog_q + CntW'(1);
        end
    end

    // Datapath: latched operands, result word, request and done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q       <= '0;
            iv_q        <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            ctr_init_q  <= 1'b0;
            ctr_next_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ctr_init_q <= start_go;
            ctr_next_q <= fetch_hs;
            done_q     <= zero_done | last_hs;

            if (start_go) begin
                key_q       <= key;
                iv_q        <= iv;
                remaining_q <= msg_len;
            end

            if (fetch_hs) begin
                word_q <= in_data;
            end

            if (word_done) begin
                out_data_q <= ctr_word_o;
                out_last_q <= (remaining_q == LEN_W'(1));
                if (remaining_q != '0) begin
                    remaining_q <= remaining_q - LEN_W'(1);
                end
            end else if ((state_q == StEmit) && (abort || out_ready)) begin
                out_last_q <= 1'b0;
            end
        end
    end

    assign ctr_key    = key_q;
    assign ctr_iv     = iv_q;
    assign ctr_word_i = word_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign ctr_init   = ctr_init_q;
    assign ctr_next   = ctr_next_q;
    assign done       = done_q;

endmodule

// File: tb/tb_zuc256_ctr_sequencer.sv
// Directed bench for zuc256_ctr_sequencer with a fixed-latency mock CTR stage.
module tb_zuc256_ctr_sequencer;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TIMEOUT = 16;
    localparam int          LAT     = 5;

    localparam logic [255:0] K1  = {8{32'h0123_4567}};
    localparam logic [255:0] K2  = {8{32'h89AB_CDEF}};
    localparam logic [255:0] K3  = {8{32'h1357_9BDF}};
    localparam logic [127:0] IV1 = {4{32'hCAFE_F00D}};

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [255:0]     key;
    logic [127:0]     iv;
    logic [LEN_W-1:0] msg_len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_last;
    logic             ctr_init;
    logic             ctr_next;
    logic [255:0]     ctr_key;
    logic [127:0]     ctr_iv;
    logic [31:0]      ctr_word_i;
    logic [31:0]      ctr_word_o = 32'hDEAD_BEEF;
    logic             ctr_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             error;

    int n_checks = 0;
    int n_fail   = 0;
    int n_init   = 0;
    int n_next   = 0;

    logic        mock_en = 1'b1;
    int          mock_cd = 0;
    logic [31:0] mock_n = '0;
    logic [31:0] mock_pend = '0;

    always #5 clk = ~clk;

    zuc256_ctr_sequencer #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .key        (key),
        .iv         (iv),
        .msg_len    (msg_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ctr_init   (ctr_init),
        .ctr_next   (ctr_next),
        .ctr_key    (ctr_key),
        .ctr_iv     (ctr_iv),
        .ctr_word_i (ctr_word_i),
        .ctr_word_o (ctr_word_o),
        .ctr_ready  (ctr_ready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Mock CTR stage: answers each request LAT cycles later with (A5A50000 + n) ^ word.
    always @(negedge clk) begin
        ctr_ready  = 1'b0;
        ctr_word_o = 32'hDEAD_BEEF;
        if (mock_cd > 0) begin
            mock_cd = mock_cd - 1;
            if (mock_cd == 0) begin
                ctr_ready  = 1'b1;
                ctr_word_o = mock_pend;
            end
        end
        if (ctr_init && mock_en) begin
            mock_n    = '0;
            mock_pend = '0;
            mock_cd   = LAT;
        end
        if (ctr_next && mock_en) begin
            mock_n    = mock_n + 32'd1;
            mock_pend = (32'hA5A5_0000 + mock_n) ^ ctr_word_i;
            mock_cd   = LAT;
        end
    end

    // Request pulse counters.
    always @(posedge clk) begin
        if (ctr_init) n_init <= n_init + 1;
        if (ctr_next) n_next <= n_next + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_busy"},     256'(busy),       256'(0));
        check({pfx, "_done"},     256'(done),       256'(0));
        check({pfx, "_error"},    256'(error),      256'(0));
        check({pfx, "_in_ready"}, 256'(in_ready),   256'(0));
        check({pfx, "_out_vld"},  256'(out_valid),  256'(0));
        check({pfx, "_out_last"}, 256'(out_last),   256'(0));
        check({pfx, "_out_data"}, 256'(out_data),   256'(0));
        check({pfx, "_init"},     256'(ctr_init),   256'(0));
        check({pfx, "_next"},     256'(ctr_next),   256'(0));
        check({pfx, "_key"},      ctr_key,          256'(0));
        check({pfx, "_iv"},       256'(ctr_iv),     256'(0));
        check({pfx, "_word_i"},   256'(ctr_word_i), 256'(0));
    endtask

    task automatic wait_in_ready();
        int b = 0;
        while (!in_ready && b < 40) begin
            tick();
            b++;
        end
        check("in_ready_wait", 256'(in_ready), 256'(1));
    endtask

    // One word through the sequencer; hold>0 keeps out_ready low that many cycles first.
    task automatic send_word(input logic [31:0] d, input logic [31:0] exp_o,
                             input logic exp_last, input int hold);
        int          lat;
        int          nx0;
        logic        stable;
        logic [31:0] held;
        wait_in_ready();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        check("ctr_next", 256'(ctr_next), 256'(1));
        check("ctr_word_i", 256'(ctr_word_i), 256'(d));
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("latency", 256'(lat), 256'(LAT + 1));
        check("out_data", 256'(out_data), 256'(exp_o));
        check("out_last", 256'(out_last), 256'(exp_last));
        if (hold > 0) begin
            stable = 1'b1;
            nx0    = n_next;
            held   = out_data;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (out_data !== held || out_last !== exp_last || out_valid !== 1'b1 ||
                    in_ready !== 1'b0) begin
                    stable = 1'b0;
                end
            end
            check("bp_hold", 256'(stable), 256'(1));
            check("bp_no_next", 256'(n_next - nx0), 256'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int   i0;
        int   x0;
        logic quiet;

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        key       = '0;
        iv        = '0;
        msg_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_cleared("rst");

        // Three-word message.
        key     = K1;
        iv      = IV1;
        msg_len = 16'd3;
        start   = 1'b1;
        i0      = n_init;
        x0      = n_next;
        tick();
        start = 1'b0;
        key   = K2;
        check("m3_init", 256'(ctr_init), 256'(1));
        check("m3_busy", 256'(busy), 256'(1));
        check("m3_key", ctr_key, K1);
        check("m3_iv", 256'(ctr_iv), 256'(IV1));
        tick();
        check("m3_init_pulse", 256'(ctr_init), 256'(0));
        send_word(32'd1, 32'hA5A5_0000, 1'b0, 0);
        send_word(32'd2, 32'hA5A5_0000, 1'b0, 0);
        send_word(32'd3, 32'hA5A5_0000, 1'b1, 0);
        check("m3_done", 256'(done), 256'(1));
        check("m3_idle", 256'(busy), 256'(0));
        tick();
        check("m3_done_pulse", 256'(done), 256'(0));
        check("m3_n_init", 256'(n_init - i0), 256'(1));
        check("m3_n_next", 256'(n_next - x0), 256'(3));
        check("m3_key_hold", ctr_key, K1);

        // Zero-length message.
        msg_len = '0;
        start   = 1'b1;
        i0      = n_init;
        tick();
        start = 1'b0;
        check("z_done", 256'(done), 256'(1));
        check("z_busy", 256'(busy), 256'(0));
        tick();
        check("z_done_pulse", 256'(done), 256'(0));
        check("z_busy2", 256'(busy), 256'(0));
        check("z_no_init", 256'(n_init - i0), 256'(0));

        // Backpressure on the second word.
        key     = K2;
        msg_len = 16'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'h0000_00F0, 32'hA5A5_00F1, 1'b0, 0);
        send_word(32'h1234_5678, 32'hB791_567A, 1'b1, 10);
        check("bp_done", 256'(done), 256'(1));
        tick();

        // Timeout: mock stays silent.
        mock_en = 1'b0;
        key     = K3;
        msg_len = 16'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("to_init", 256'(ctr_init), 256'(1));
        repeat (16) tick();
        check("to_err_early", 256'(error), 256'(0));
        tick();
        check("to_err", 256'(error), 256'(1));
        check("to_busy", 256'(busy), 256'(1));
        key   = K1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_start_ign", 256'(ctr_init), 256'(0));
        check("to_err_hold", 256'(error), 256'(1));
        check("to_key_hold", ctr_key, K3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("to_err_clr", 256'(error), 256'(0));
        check("to_idle", 256'(busy), 256'(0));
        mock_en = 1'b1;

        // Abort two cycles after ctr_next.
        key     = K1;
        msg_len = 16'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        wait_in_ready();
        in_valid = 1'b1;
        in_data  = 32'hAAAA_5555;
        tick();
        in_valid = 1'b0;
        check("ab_next", 256'(ctr_next), 256'(1));
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_drain_busy", 256'(busy), 256'(1));
        quiet = (out_valid === 1'b0);
        tick();
        quiet = quiet && (out_valid === 1'b0) && (busy === 1'b1);
        tick();
        quiet = quiet && (out_valid === 1'b0);
        check("ab_no_out", 256'(quiet), 256'(1));
        check("ab_busy_at_ready", 256'(busy), 256'(1));
        tick();
        check("ab_idle", 256'(busy), 256'(0));
        key   = K2;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'hFFFF_0000, 32'h5A5A_0001, 1'b1, 0);
        check("ab_restart_done", 256'(done), 256'(1));
        tick();

        // Reset mid-message, then a stray ctr_ready must be ignored.
        key     = K3;
        msg_len = 16'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared("mrst");
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
                ctr_init !== 1'b0 || done !== 1'b0) begin
                quiet = 1'b0;
            end
        end
        check("mrst_ready_ignored", 256'(quiet), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
